// File: rtl/mmio_responder_pkg.sv
// Shared types and decode helpers for the blocking MMIO responder.
package mmio_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ID_VALUE   = 32'h4B414E41;
    localparam logic [31:0] DEFAULT_MISS_VALUE = 32'hDEADBEEF;

    // span is the window size in bytes (a power of two).
    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
        return (addr & ~(span - 32'd1)) == base;
    endfunction

    function automatic logic [31:0] win_index(input logic [31:0] addr,
                                              input logic [31:0] span);
        return (addr >> 2) & ((span >> 2) - 32'd1);
    endfunction

endpackage

// File: rtl/mmio_responder_regfile.sv
// Register window: index 0 is a read-only ID, the rest are writable 32-bit flops.
module mmio_responder_regfile #(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'h4B414E41,
    localparam int         IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] regs [NUM_REGS];

    assign regs[0] = ID_VALUE;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs[gi] <= 32'h0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    regs[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/mmio_blocking_responder.sv
// Blocking MMIO load/store responder with a small register window.
// Optional out-of-window counter enabled by MMIO_RESPONDER_ERR_COUNT_EN.
module mmio_blocking_responder
    import mmio_responder_pkg::*;
#(
    parameter int          NUM_REGS     = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h10000000,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] ID_VALUE     = DEFAULT_ID_VALUE,
    parameter logic [31:0] MISS_VALUE   = DEFAULT_MISS_VALUE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req_empty_in,
    output logic        load_req_rden_out,
    input  logic [31:0] load_req_addr_in,
    input  logic        load_rsp_rdy_in,
    output logic        load_rsp_valid_out,
    output logic [31:0] load_rsp_result_out,
    input  logic        store_req_empty_in,
    output logic        store_req_rden_out,
    input  logic [31:0] store_req_addr_in,
    input  logic [31:0] store_req_value_in,
    output logic [15:0] err_count_out
);

    localparam int          IDX_W = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] result_reg, result_next;

    logic             load_pop, store_pop;
    logic             load_hit, store_hit;
    logic [IDX_W-1:0] load_idx, store_idx;
    logic [31:0]      rd_data;
    logic             wr_en;

    assign load_hit  = win_hit(load_req_addr_in, BASE_ADDR, SPAN);
    assign store_hit = win_hit(store_req_addr_in, BASE_ADDR, SPAN);
    assign load_idx  = IDX_W'(win_index(load_req_addr_in, SPAN));
    assign store_idx = IDX_W'(win_index(store_req_addr_in, SPAN));

    // Stores win the arbitration, so a load never samples the bank while a store is in flight.
    assign store_pop = !store_req_empty_in;
    assign load_pop  = (state_reg == IDLE) && !load_req_empty_in && store_req_empty_in;

    assign store_req_rden_out  = store_pop;
    assign load_req_rden_out   = load_pop;
    assign load_rsp_result_out = result_reg;

    assign wr_en = store_pop && store_hit && (store_idx != '0);

    mmio_responder_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (store_idx),
        .wr_data (store_req_value_in),
        .rd_idx  (load_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 4'd0;
            result_reg <= 32'h0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        count_next         = count_reg;
        result_next        = result_reg;
        load_rsp_valid_out = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_pop) begin
                    result_next = load_hit ? rd_data : MISS_VALUE;
                    if (READ_LATENCY == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(READ_LATENCY);
                    end
                end
            end
            WAIT: begin
                // Counter starts at READ_LATENCY; the last WAIT cycle is the one holding 1.
                count_next = count_reg - 4'd1;
                if (count_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                load_rsp_valid_out = load_rsp_rdy_in;
                if (load_rsp_rdy_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MMIO_RESPONDER_ERR_COUNT_EN
    logic [15:0] err_count_reg;
    logic        err_event;

    // Load and store pops are mutually exclusive, so at most one miss per cycle.
    assign err_event = (load_pop && !load_hit) || (store_pop && !store_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= 16'h0;
        end else if (err_event && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count_out = err_count_reg;
`else
    assign err_count_out = 16'h0;
`endif

endmodule

// File: tb/tb_mmio_blocking_responder.sv
// Directed bench for mmio_blocking_responder (default parameters).
module tb_mmio_blocking_responder;

    logic        clk;
    logic        rst;
    logic        load_req_empty_in;
    logic        load_req_rden_out;
    logic [31:0] load_req_addr_in;
    logic        load_rsp_rdy_in;
    logic        load_rsp_valid_out;
    logic [31:0] load_rsp_result_out;
    logic        store_req_empty_in;
    logic        store_req_rden_out;
    logic [31:0] store_req_addr_in;
    logic [31:0] store_req_value_in;
    logic [15:0] err_count_out;

`ifdef MMIO_RESPONDER_ERR_COUNT_EN
    localparam logic [31:0] EXP_ERR = 32'd2;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    mmio_blocking_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_req_empty_in   (load_req_empty_in),
        .load_req_rden_out   (load_req_rden_out),
        .load_req_addr_in    (load_req_addr_in),
        .load_rsp_rdy_in     (load_rsp_rdy_in),
        .load_rsp_valid_out  (load_rsp_valid_out),
        .load_rsp_result_out (load_rsp_result_out),
        .store_req_empty_in  (store_req_empty_in),
        .store_req_rden_out  (store_req_rden_out),
        .store_req_addr_in   (store_req_addr_in),
        .store_req_value_in  (store_req_value_in),
        .err_count_out       (err_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] val);
        store_req_addr_in  = addr;
        store_req_value_in = val;
        store_req_empty_in = 1'b0;
        #1;
        chk({tag, "_st_pop"}, 32'(store_req_rden_out), 32'd1);
        @(posedge clk); #1;
        store_req_empty_in = 1'b1;
    endtask

    // Called in the cycle after the pop; expects valid in pop+3 with rdy high.
    task automatic wait_rsp(input string tag, input logic [31:0] exp);
        int lat = 1;
        #1;
        while (!load_rsp_valid_out && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_data"}, load_rsp_result_out, exp);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int n = 0;
        load_req_addr_in  = addr;
        load_req_empty_in = 1'b0;
        load_rsp_rdy_in   = 1'b1;
        #1;
        while (!load_req_rden_out && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_ld_pop"}, 32'(load_req_rden_out), 32'd1);
        @(posedge clk); #1;
        load_req_empty_in = 1'b1;
        wait_rsp(tag, exp);
    endtask

    initial begin
        int blk_bad;
        int stray;
        rst                = 1'b1;
        load_req_empty_in  = 1'b1;
        load_req_addr_in   = 32'h0;
        load_rsp_rdy_in    = 1'b1;
        store_req_empty_in = 1'b1;
        store_req_addr_in  = 32'h0;
        store_req_value_in = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  32'(load_rsp_valid_out), 32'd0);
        chk("rst_result", load_rsp_result_out, 32'h0);
        chk("rst_ld_rden", 32'(load_req_rden_out), 32'd0);
        chk("rst_st_rden", 32'(store_req_rden_out), 32'd0);
        chk("rst_err", 32'(err_count_out), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic store then load
        do_store("s8", 32'h10000008, 32'h12345678);
        do_load("l8", 32'h10000008, 32'h12345678);

        // ID register is read-only and writes to it are not errors
        do_load("id0", 32'h10000000, 32'h4B414E41);
        do_store("s0", 32'h10000000, 32'h0);
        do_load("id1", 32'h10000000, 32'h4B414E41);
        chk("err_after_id", 32'(err_count_out), 32'h0);

        // Out-of-window accesses
        do_load("miss", 32'h20000000, 32'hDEADBEEF);
        do_store("smiss", 32'h20000004, 32'h1);
        chk("err_after_miss", 32'(err_count_out), EXP_ERR);
        do_load("r1", 32'h10000004, 32'h0);

        // Store and load pending in the same cycle: store first
        store_req_addr_in  = 32'h1000000C;
        store_req_value_in = 32'h0BADF00D;
        store_req_empty_in = 1'b0;
        load_req_addr_in   = 32'h1000000C;
        load_req_empty_in  = 1'b0;
        #1;
        chk("prio_st", 32'(store_req_rden_out), 32'd1);
        chk("prio_ld_blocked", 32'(load_req_rden_out), 32'd0);
        @(posedge clk); #1;
        store_req_empty_in = 1'b1;
        #1;
        chk("prio_ld_next", 32'(load_req_rden_out), 32'd1);
        @(posedge clk); #1;
        load_req_empty_in = 1'b1;
        wait_rsp("prio", 32'h0BADF00D);

        // Backpressure: rdy low while a second load waits and a store streams in
        load_rsp_rdy_in   = 1'b0;
        load_req_addr_in  = 32'h10000008;
        load_req_empty_in = 1'b0;
        #1;
        chk("bp_pop", 32'(load_req_rden_out), 32'd1);
        @(posedge clk); #1;
        blk_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                store_req_addr_in  = 32'h10000008;
                store_req_value_in = 32'hCAFEF00D;
                store_req_empty_in = 1'b0;
            end
            #1;
            if (i == 2) chk("bp_st_pop", 32'(store_req_rden_out), 32'd1);
            if (load_rsp_valid_out || load_req_rden_out) blk_bad++;
            @(posedge clk); #1;
            store_req_empty_in = 1'b1;
        end
        chk("bp_blocked", 32'(blk_bad), 32'd0);
        load_rsp_rdy_in = 1'b1;
        #1;
        chk("bp_valid", 32'(load_rsp_valid_out), 32'd1);
        chk("bp_data", load_rsp_result_out, 32'h12345678);
        @(posedge clk); #2;
        chk("bp_one_pulse", 32'(load_rsp_valid_out), 32'd0);
        chk("bp_next_pop", 32'(load_req_rden_out), 32'd1);
        @(posedge clk); #1;
        load_req_empty_in = 1'b1;
        wait_rsp("bp2", 32'hCAFEF00D);

        // Reset during WAIT discards the load
        load_req_addr_in  = 32'h10000008;
        load_req_empty_in = 1'b0;
        #1;
        chk("rw_pop", 32'(load_req_rden_out), 32'd1);
        @(posedge clk); #1;
        load_req_empty_in = 1'b1;
        rst = 1'b1;
        #1;
        chk("rw_rst_result", load_rsp_result_out, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (load_rsp_valid_out) stray++;
        end
        chk("rw_no_rsp", 32'(stray), 32'd0);
        do_load("rw_r2", 32'h10000008, 32'h0);
        do_load("rw_r3", 32'h1000000C, 32'h0);
        do_load("rw_id", 32'h10000000, 32'h4B414E41);
        chk("rw_err", 32'(err_count_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_blocking_responder.md
Name: mmio_blocking_responder

Overview:
- Downstream MMIO device serving the RISC-V MMIO wrapper's blocking load/store request queues: pops store requests into a small register bank; pops load requests and returns read data on the load-result handshake.
- Stands in for a real peripheral and doubles as the bench-side device model in processor MMIO tests.
- One blocking load outstanding at a time; stores stream at one per cycle.

Parameters:
- NUM_REGS, 8, number of 32-bit registers in the window; power of two, >= 2.
- BASE_ADDR, 32'h10000000, byte base of the window; aligned to NUM_REGS*4.
- READ_LATENCY, 2, extra cycles between load pop and result availability; range 0..15.
- ID_VALUE, 32'h4B414E41, read-only contents of register index 0.
- MISS_VALUE, 32'hDEADBEEF, load result for an out-of-window address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_req_empty_in  in  1  load request queue empty
- load_req_rden_out  out  1  pop load request
- load_req_addr_in  in  32  load byte address, valid when !empty
- load_rsp_rdy_in  in  1  wrapper can accept a result this cycle
- load_rsp_valid_out  out  1  result transfer this cycle
- load_rsp_result_out  out  32  result data
- store_req_empty_in  in  1  store request queue empty
- store_req_rden_out  out  1  pop store request
- store_req_addr_in  in  32  store byte address
- store_req_value_in  in  32  store data
- err_count_out  out  16  out-of-window access count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE, all registers 0, latency counter 0, result register 0. All outputs 0.
- Decode:
  - hit = (addr & ~(NUM_REGS*4-1)) == BASE_ADDR.
  - idx = addr[2 +: $clog2(NUM_REGS)].
  - addr[1:0] ignored; no byte enables.
- Store path:
  - store_req_rden_out = !store_req_empty_in, independent of load state.
  - On the popping edge: hit with idx != 0 writes reg[idx]; hit with idx == 0 is silently dropped (not an error); a miss is dropped and counted.
- Load FSM, states IDLE, WAIT, RESP:
  - load_req_rden_out = (state==IDLE) && !load_req_empty_in && store_req_empty_in. Stores have priority, so pending stores drain before a load samples, and a load never pops in the same cycle as a store.
  - Pop cycle T: capture reg[idx], ID_VALUE (idx 0) or MISS_VALUE (miss; counted). Then go to WAIT with counter = READ_LATENCY, or to RESP if READ_LATENCY == 0.
  - WAIT: decrement each cycle; on reaching 0, go to RESP. With no stall, the result first appears in cycle T+1+READ_LATENCY.
  - RESP: load_rsp_valid_out = load_rsp_rdy_in (combinational); load_rsp_result_out holds the captured value throughout RESP.
  - When valid && rdy, return to IDLE. The next load pop is possible the following cycle.
  - rdy low in RESP: hold RESP and the data indefinitely.
- Stores accepted during WAIT/RESP update registers but never alter the already-captured result.
- Reset mid-operation: the pending load is discarded, no response is issued, and the popped request is lost.
- Result register width is exactly 32 bits; no sign extension.

Optional Feature:
- Macro MMIO_RESPONDER_ERR_COUNT_EN.
- Defined: 16-bit counter, reset 0, +1 per out-of-window load pop and per out-of-window store pop (never both in one cycle); saturates at 16'hFFFF; drives err_count_out.
- Undefined: no counter logic; err_count_out tied to 16'h0.

Decomposition:
- Shared package mmio_responder_pkg:
  - state enum (IDLE/WAIT/RESP)
  - localparam DEFAULT_ID_VALUE, DEFAULT_MISS_VALUE
  - function for window hit/index decode
- One natural sub-module, mmio_responder_regfile: NUM_REGS x 32 flops, one write port, one combinational read port, index 0 hard-wired to ID_VALUE.
- FSM, handshakes and error counter stay in the top module.

Test Plan:
- Store 0x10000008 <- 0x12345678, then load 0x10000008, rdy high, READ_LATENCY=2 -> rsp valid exactly 3 cycles after load pop, result 0x12345678.
- Load 0x10000000 -> 0x4B414E41; store 0x10000000 <- 0 then reload -> still 0x4B414E41, err_count 0.
- Load 0x20000000 -> 0xDEADBEEF; store 0x20000004 <- 1 -> dropped. With macro: err_count_out == 2. Without macro: err_count_out == 0.
- Store and load to 0x1000000C pending in the same cycle -> store pops first, load pops the next cycle, result equals the stored value.
- Hold rdy low for 5 cycles in RESP, then raise -> exactly one valid pulse with held data, no extra load_req_rden_out while blocked; stores continue popping meanwhile.
- Assert rst during WAIT -> no response; after release, registers read 0 except idx 0, and a new load completes normally.
